burst_ram_arbiter: RTL and testbench
====================================

Name: burst_ram_arbiter

Overview:
- Two-client arbiter between the cache layer and the single BurstRAM port.
- Client 0 is the instruction cache (reads only in practice). Client 1 is the data cache (reads and writes).
- Each client sees a BurstRAM-identical interface. Each client has a one-deep request slot that buffers the full write burst.
- Slots are serialised onto br_* with round-robin arbitration. Read beats are routed back only to the owning client.

Parameters:
- RAM_DEPTH_BITWIDTH, 4, width of burst address.
- RAM_BURST_DATA_BITWIDTH, 64, width of one beat; must be divisible by 8.
- RAM_BURST_DATA_COUNT, 4, beats per burst; power of two, >=2.

Ports:
- clk input 1 — clock.
- rst input 1 — asynchronous, active-high reset.
- cN_cmd input 1 (N=0,1) — 0 read, 1 write.
- cN_cmd_en input 1 — one-cycle request strobe.
- cN_addr input RAM_DEPTH_BITWIDTH — burst address.
- cN_wr_data input RAM_BURST_DATA_BITWIDTH — write beat.
- cN_data_mask input RAM_BURST_DATA_BITWIDTH/8 — byte mask per beat; 1 = byte masked.
- cN_rd_data output RAM_BURST_DATA_BITWIDTH — read beat.
- cN_rd_data_valid output 1 — read beat strobe for client N.
- cN_busy output 1 — client N slot occupied; cmd_en ignored.
- br_cmd output 1 — command to BurstRAM.
- br_cmd_en output 1 — command strobe to BurstRAM.
- br_addr output RAM_DEPTH_BITWIDTH — burst address to BurstRAM.
- br_wr_data output RAM_BURST_DATA_BITWIDTH — write beat to BurstRAM.
- br_data_mask output RAM_BURST_DATA_BITWIDTH/8 — byte mask to BurstRAM.
- br_rd_data input RAM_BURST_DATA_BITWIDTH — read beat from BurstRAM.
- br_rd_data_valid input 1 — read beat strobe from BurstRAM.
- br_busy input 1 — BurstRAM busy.

Behaviour:
- Reset (async, rst=1):
  - state IDLE.
  - Both slots invalid.
  - last_grant=1, so client 0 wins the first tie.
  - All registered outputs 0: br_cmd_en, br_cmd, br_addr, br_wr_data, br_data_mask, cN_busy.
  - Reset mid-burst aborts silently. No further br_cmd_en until a new request arrives.
- Client accept:
  - cN_cmd_en is sampled only when cN_busy=0. It latches cmd, addr, beat0 data and mask. cN_busy=1 from the next cycle.
  - cmd_en while busy is ignored, with no side effects.
- Write capture:
  - Beats 1..COUNT-1 are captured on the COUNT-1 cycles immediately following cmd_en.
  - The slot becomes eligible only after the last beat is captured.
- Arbitration happens in IDLE when br_busy=0:
  - Only one slot eligible: grant it.
  - Both eligible: grant the client != last_grant.
  - last_grant updates on grant.
- FSM states: IDLE, ISSUE, WRITE, READ.
  - IDLE -> ISSUE on grant.
  - ISSUE: br_cmd_en=1 for exactly one cycle, with br_cmd, br_addr and beat0 data/mask. Then go to WRITE if cmd=1, else READ.
  - WRITE: drive beats 1..COUNT-1 on consecutive cycles, no gaps. After the last beat: free the slot (cN_busy=0 next cycle) and go to IDLE.
  - READ: count br_rd_data_valid beats. After beat COUNT-1: free the slot and go to IDLE.
- Read path:
  - cN_rd_data = br_rd_data (combinational, both clients).
  - cN_rd_data_valid = br_rd_data_valid & state==READ & owner==N.
  - Valid beats outside READ are dropped.
- Latency, arbiter idle and br_busy=0:
  - Read: cmd_en in cycle C -> br_cmd_en in cycle C+2.
  - Write: last beat captured in cycle C+COUNT-1 -> br_cmd_en in cycle C+COUNT+1.
- Back-to-back:
  - IDLE re-checks br_busy, so a new grant waits until br_busy=0.
  - A freed client may issue a new cmd_en in the first cycle cN_busy=0. That request can be granted ahead of a waiting peer only if the peer slot is not yet eligible.
- Simultaneous events:
  - Both cmd_en in the same cycle: both are accepted into their own slots.
  - Slot free and new cmd_en in the same cycle: not possible, because busy is registered.
- Counters:
  - Beat counters are log2(COUNT) bits and wrap to 0 at burst end.
  - No beat index exceeds COUNT-1.

Test Plan:
- Single read: after reset, c0 reads addr=5.
  - br_cmd_en=1 with br_cmd=0 and br_addr=5 in cycle C+2.
  - Model returns 4 beats 0x11..0x44. c0_rd_data_valid pulses 4 times with those values. c1_rd_data_valid stays 0.
  - c0_busy falls after beat 4.
- Single write: c1 writes addr=9 with beats 0xA0..0xA3, mask 0x00/0x0F/0xF0/0xFF.
  - br_cmd_en in cycle C+5.
  - br_wr_data/br_data_mask replay those 4 beats on 4 consecutive cycles.
- Tie: c0 read addr=1 and c1 read addr=2 in the same cycle, after reset.
  - c0 is granted first, then c1.
  - Next tie: c1 is granted first (round-robin).
- br_busy held 1 for 10 cycles while c1 is pending -> no br_cmd_en until br_busy=0, then grant.
- cmd_en from c0 while c0_busy=1 (addr=7) -> ignored. Only the original address is issued and no second burst follows.
- rst asserted in WRITE after beat 1 -> outputs 0 immediately, cN_busy=0, no further br_cmd_en.
  - A new c0 read after reset issues normally.

Source files
------------

// File: rtl/burst_ram_arbiter.sv
// Two-client round-robin arbiter in front of a single BurstRAM port.
// Each client owns a one-deep slot that holds a full write burst.
module burst_ram_arbiter #(
   parameter int RAM_DEPTH_BITWIDTH      = 4,
   parameter int RAM_BURST_DATA_BITWIDTH = 64,
   parameter int RAM_BURST_DATA_COUNT    = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 c0_cmd,
   input  logic                                 c0_cmd_en,
   input  logic [RAM_DEPTH_BITWIDTH-1:0]        c0_addr,
   input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   c0_wr_data,
   input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] c0_data_mask,
   output logic [RAM_BURST_DATA_BITWIDTH-1:0]   c0_rd_data,
   output logic                                 c0_rd_data_valid,
   output logic                                 c0_busy,
   input  logic                                 c1_cmd,
   input  logic                                 c1_cmd_en,
   input  logic [RAM_DEPTH_BITWIDTH-1:0]        c1_addr,
   input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   c1_wr_data,
   input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] c1_data_mask,
   output logic [RAM_BURST_DATA_BITWIDTH-1:0]   c1_rd_data,
   output logic                                 c1_rd_data_valid,
   output logic                                 c1_busy,
   output logic                                 br_cmd,
   output logic                                 br_cmd_en,
   output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
   output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
   output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
   input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
   input  logic                                 br_rd_data_valid,
   input  logic                                 br_busy
);

   localparam int AW = RAM_DEPTH_BITWIDTH;
   localparam int DW = RAM_BURST_DATA_BITWIDTH;
   localparam int MW = DW / 8;
   localparam int CNT = RAM_BURST_DATA_COUNT;
   localparam int CW = $clog2(CNT);
   localparam logic [CW-1:0] LAST = CW'(CNT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WRITE, READ} state_t;

   state_t r_state;
   state_t w_next;

   logic [1:0]    w_cmd_en;
   logic [1:0]    w_in_cmd;
   logic [AW-1:0] w_in_addr [2];
   logic [DW-1:0] w_in_data [2];
   logic [MW-1:0] w_in_mask [2];

   logic [1:0]    r_busy;
   logic [1:0]    r_ready;
   logic [1:0]    r_cap;
   logic [1:0]    r_cmd;
   logic [AW-1:0] r_addr [2];
   logic [CW-1:0] r_cap_cnt [2];
   logic [DW-1:0] r_data [2][CNT];
   logic [MW-1:0] r_mask [2][CNT];

   logic          r_owner;
   logic          r_last;
   logic [CW-1:0] r_beat;

   logic          w_gnt_vld;
   logic          w_gnt;
   logic          w_last_beat;
   logic          w_done;
   logic [1:0]    w_free;

   logic          w_nxt_cmd_en;
   logic          w_nxt_cmd;
   logic [AW-1:0] w_nxt_addr;
   logic [DW-1:0] w_nxt_data;
   logic [MW-1:0] w_nxt_mask;

   logic          r_br_cmd_en;
   logic          r_br_cmd;
   logic [AW-1:0] r_br_addr;
   logic [DW-1:0] r_br_data;
   logic [MW-1:0] r_br_mask;

   assign w_cmd_en     = {c1_cmd_en, c0_cmd_en};
   assign w_in_cmd     = {c1_cmd, c0_cmd};
   assign w_in_addr[0] = c0_addr;
   assign w_in_addr[1] = c1_addr;
   assign w_in_data[0] = c0_wr_data;
   assign w_in_data[1] = c1_wr_data;
   assign w_in_mask[0] = c0_data_mask;
   assign w_in_mask[1] = c1_data_mask;

   // Tie goes to the client that was not granted last.
   assign w_gnt_vld = (r_state == IDLE) && !br_busy && (|r_ready);
   assign w_gnt     = (&r_ready) ? ~r_last : r_ready[1];

   assign w_last_beat = (r_beat == LAST);
   assign w_done = ((r_state == WRITE) && w_last_beat) ||
                   ((r_state == READ) && br_rd_data_valid && w_last_beat);
   assign w_free[0] = w_done && !r_owner;
   assign w_free[1] = w_done && r_owner;

   // Slot accept, write-beat capture and release per client.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy  <= '0;
         r_ready <= '0;
         r_cap   <= '0;
         r_cmd   <= '0;
         for (int n = 0; n < 2; n++) begin
            r_addr[n]    <= '0;
            r_cap_cnt[n] <= '0;
            for (int b = 0; b < CNT; b++) begin
               r_data[n][b] <= '0;
               r_mask[n][b] <= '0;
            end
         end
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (!r_busy[n] && w_cmd_en[n]) begin
               r_busy[n]    <= 1'b1;
               r_cmd[n]     <= w_in_cmd[n];
               r_addr[n]    <= w_in_addr[n];
               r_data[n][0] <= w_in_data[n];
               r_mask[n][0] <= w_in_mask[n];
               r_cap[n]     <= w_in_cmd[n];
               r_ready[n]   <= ~w_in_cmd[n];
               r_cap_cnt[n] <= CW'(1);
            end else if (r_cap[n]) begin
               r_data[n][r_cap_cnt[n]] <= w_in_data[n];
               r_mask[n][r_cap_cnt[n]] <= w_in_mask[n];
               r_cap_cnt[n] <= r_cap_cnt[n] + CW'(1);
               if (r_cap_cnt[n] == LAST) begin
                  r_cap[n]   <= 1'b0;
                  r_ready[n] <= 1'b1;
               end
            end
            if (w_free[n]) begin
               r_busy[n]  <= 1'b0;
               r_ready[n] <= 1'b0;
            end
         end
      end
   end

   // State register plus grant history and beat counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_owner <= 1'b0;
         r_last  <= 1'b1;
         r_beat  <= '0;
      end else begin
         r_state <= w_next;
         if (w_gnt_vld) begin
            r_owner <= w_gnt;
            r_last  <= w_gnt;
         end
         unique case (r_state)
            IDLE:  r_beat <= '0;
            ISSUE: r_beat <= r_cmd[r_owner] ? CW'(1) : '0;
            WRITE: r_beat <= r_beat + CW'(1);
            READ:  if (br_rd_data_valid) r_beat <= r_beat + CW'(1);
            default: r_beat <= '0;
         endcase
      end
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:  if (w_gnt_vld) w_next = ISSUE;
         ISSUE: w_next = r_cmd[r_owner] ? WRITE : READ;
         WRITE: if (w_last_beat) w_next = IDLE;
         READ:  if (w_done) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Next values of the registered BurstRAM outputs.
   always_comb begin
      w_nxt_cmd_en = 1'b0;
      w_nxt_cmd    = 1'b0;
      w_nxt_addr   = '0;
      w_nxt_data   = '0;
      w_nxt_mask   = '0;
      if (w_gnt_vld) begin
         w_nxt_cmd_en = 1'b1;
         w_nxt_cmd    = r_cmd[w_gnt];
         w_nxt_addr   = r_addr[w_gnt];
         w_nxt_data   = r_data[w_gnt][0];
         w_nxt_mask   = r_mask[w_gnt][0];
      end else if ((r_state == ISSUE) && r_cmd[r_owner]) begin
         w_nxt_data = r_data[r_owner][CW'(1)];
         w_nxt_mask = r_mask[r_owner][CW'(1)];
      end else if ((r_state == WRITE) && !w_last_beat) begin
         w_nxt_data = r_data[r_owner][r_beat + CW'(1)];
         w_nxt_mask = r_mask[r_owner][r_beat + CW'(1)];
      end
   end

   // Output registers toward BurstRAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_br_cmd_en <= 1'b0;
         r_br_cmd    <= 1'b0;
         r_br_addr   <= '0;
         r_br_data   <= '0;
         r_br_mask   <= '0;
      end else begin
         r_br_cmd_en <= w_nxt_cmd_en;
         r_br_cmd    <= w_nxt_cmd;
         r_br_addr   <= w_nxt_addr;
         r_br_data   <= w_nxt_data;
         r_br_mask   <= w_nxt_mask;
      end
   end

   assign br_cmd_en    = r_br_cmd_en;
   assign br_cmd       = r_br_cmd;
   assign br_addr      = r_br_addr;
   assign br_wr_data   = r_br_data;
   assign br_data_mask = r_br_mask;

   assign c0_busy = r_busy[0];
   assign c1_busy = r_busy[1];

   assign c0_rd_data = br_rd_data;
   assign c1_rd_data = br_rd_data;
   assign c0_rd_data_valid = br_rd_data_valid && (r_state == READ) && !r_owner;
   assign c1_rd_data_valid = br_rd_data_valid && (r_state == READ) && r_owner;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter: latency, routing,
// round-robin, br_busy stall, busy drop and mid-burst reset.
module tb_burst_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        c0_cmd = 0, c0_cmd_en = 0;
   logic [3:0]  c0_addr = 0;
   logic [63:0] c0_wr_data = 0;
   logic [7:0]  c0_data_mask = 0;
   logic [63:0] c0_rd_data;
   logic        c0_rd_data_valid, c0_busy;
   logic        c1_cmd = 0, c1_cmd_en = 0;
   logic [3:0]  c1_addr = 0;
   logic [63:0] c1_wr_data = 0;
   logic [7:0]  c1_data_mask = 0;
   logic [63:0] c1_rd_data;
   logic        c1_rd_data_valid, c1_busy;
   logic        br_cmd, br_cmd_en;
   logic [3:0]  br_addr;
   logic [63:0] br_wr_data;
   logic [7:0]  br_data_mask;
   logic [63:0] br_rd_data = 0;
   logic        br_rd_data_valid = 0;
   logic        br_busy = 0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   burst_ram_arbiter dut (
      .clk(clk), .rst(rst),
      .c0_cmd(c0_cmd), .c0_cmd_en(c0_cmd_en), .c0_addr(c0_addr),
      .c0_wr_data(c0_wr_data), .c0_data_mask(c0_data_mask),
      .c0_rd_data(c0_rd_data), .c0_rd_data_valid(c0_rd_data_valid),
      .c0_busy(c0_busy),
      .c1_cmd(c1_cmd), .c1_cmd_en(c1_cmd_en), .c1_addr(c1_addr),
      .c1_wr_data(c1_wr_data), .c1_data_mask(c1_data_mask),
      .c1_rd_data(c1_rd_data), .c1_rd_data_valid(c1_rd_data_valid),
      .c1_busy(c1_busy),
      .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
      .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
      .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
      .br_busy(br_busy)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic req(input int cl, input logic cmd, input logic [3:0] a,
                      input logic [63:0] d, input logic [7:0] m);
      if (cl == 0) begin
         c0_cmd = cmd; c0_cmd_en = 1; c0_addr = a;
         c0_wr_data = d; c0_data_mask = m;
      end else begin
         c1_cmd = cmd; c1_cmd_en = 1; c1_addr = a;
         c1_wr_data = d; c1_data_mask = m;
      end
   endtask

   task automatic clr_in();
      c0_cmd_en = 0; c0_cmd = 0; c0_wr_data = 0; c0_data_mask = 0;
      c1_cmd_en = 0; c1_cmd = 0; c1_wr_data = 0; c1_data_mask = 0;
   endtask

   // Called at the negedge of the first READ cycle; the slot is
   // expected to be free at the negedge after the fourth beat.
   task automatic feed_rd(input int cl, input logic [63:0] base,
                          input logic [63:0] step);
      logic [63:0] v;
      for (int i = 0; i < 4; i++) begin
         v = base + step * 64'(i);
         br_rd_data = v;
         br_rd_data_valid = 1;
         #1;
         if (cl == 0) begin
            chk("rd0_vld", 64'(c0_rd_data_valid), 1);
            chk("rd0_data", c0_rd_data, v);
            chk("rd0_peer_quiet", 64'(c1_rd_data_valid), 0);
            chk("rd0_busy", 64'(c0_busy), 1);
         end else begin
            chk("rd1_vld", 64'(c1_rd_data_valid), 1);
            chk("rd1_data", c1_rd_data, v);
            chk("rd1_peer_quiet", 64'(c0_rd_data_valid), 0);
            chk("rd1_busy", 64'(c1_busy), 1);
         end
         @(negedge clk);
      end
      br_rd_data_valid = 0;
      br_rd_data = 0;
      chk("rd_free", 64'(cl == 0 ? c0_busy : c1_busy), 0);
   endtask

   task automatic count_cmd(input int n, output int c);
      c = 0;
      repeat (n) begin
         @(negedge clk);
         if (br_cmd_en) c++;
      end
   endtask

   task automatic do_reset();
      rst = 1;
      @(negedge clk);
      @(negedge clk);
      rst = 0;
   endtask

   logic [7:0]  mk [4];
   logic [7:0]  mk2 [4];
   int          cnt;

   initial begin
      mk[0] = 8'h00; mk[1] = 8'h0F; mk[2] = 8'hF0; mk[3] = 8'hFF;
      mk2[0] = 8'h11; mk2[1] = 8'h22; mk2[2] = 8'h33; mk2[3] = 8'h44;
      @(negedge clk);
      @(negedge clk);
      chk("rst_cmd_en", 64'(br_cmd_en), 0);
      chk("rst_cmd", 64'(br_cmd), 0);
      chk("rst_addr", 64'(br_addr), 0);
      chk("rst_wdata", br_wr_data, 0);
      chk("rst_mask", 64'(br_data_mask), 0);
      chk("rst_c0_busy", 64'(c0_busy), 0);
      chk("rst_c1_busy", 64'(c1_busy), 0);
      rst = 0;

      // Single read, c0 addr 5.
      @(negedge clk);
      req(0, 0, 4'd5, 0, 0);
      @(negedge clk);
      clr_in();
      chk("rd_c1_busy", 64'(c0_busy), 1);
      chk("rd_c1_noen", 64'(br_cmd_en), 0);
      @(negedge clk);
      chk("rd_c2_en", 64'(br_cmd_en), 1);
      chk("rd_c2_cmd", 64'(br_cmd), 0);
      chk("rd_c2_addr", 64'(br_addr), 5);
      @(negedge clk);
      feed_rd(0, 64'h11, 64'h11);

      // Single write, c1 addr 9.
      req(1, 1, 4'd9, 64'hA0, mk[0]);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         c1_cmd_en = 0;
         c1_wr_data = 64'hA0 + 64'(i);
         c1_data_mask = mk[i];
      end
      @(negedge clk);
      clr_in();
      chk("wr_c4_noen", 64'(br_cmd_en), 0);
      @(negedge clk);
      chk("wr_c5_en", 64'(br_cmd_en), 1);
      chk("wr_c5_cmd", 64'(br_cmd), 1);
      chk("wr_c5_addr", 64'(br_addr), 9);
      chk("wr_b0_data", br_wr_data, 64'hA0);
      chk("wr_b0_mask", 64'(br_data_mask), 64'(mk[0]));
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         chk("wr_bn_noen", 64'(br_cmd_en), 0);
         chk("wr_bn_data", br_wr_data, 64'hA0 + 64'(i));
         chk("wr_bn_mask", 64'(br_data_mask), 64'(mk[i]));
      end
      @(negedge clk);
      chk("wr_free", 64'(c1_busy), 0);

      // Tie after reset: c0 first, then c1.
      do_reset();
      req(0, 0, 4'd1, 0, 0);
      req(1, 0, 4'd2, 0, 0);
      @(negedge clk);
      clr_in();
      @(negedge clk);
      chk("tie1_en", 64'(br_cmd_en), 1);
      chk("tie1_addr_c0", 64'(br_addr), 1);
      @(negedge clk);
      feed_rd(0, 64'h100, 1);
      // c0 re-requests at once; c1 is already eligible and wins.
      req(0, 0, 4'd3, 0, 0);
      @(negedge clk);
      clr_in();
      chk("tie1_en2", 64'(br_cmd_en), 1);
      chk("tie1_addr_c1", 64'(br_addr), 2);
      @(negedge clk);
      feed_rd(1, 64'h200, 1);
      chk("rr_idle_noen", 64'(br_cmd_en), 0);
      @(negedge clk);
      chk("rr_c0_en", 64'(br_cmd_en), 1);
      chk("rr_c0_addr", 64'(br_addr), 3);
      @(negedge clk);
      feed_rd(0, 64'h300, 1);

      // Second tie: c0 was granted last, so c1 goes first.
      req(0, 0, 4'd4, 0, 0);
      req(1, 0, 4'd6, 0, 0);
      @(negedge clk);
      clr_in();
      @(negedge clk);
      chk("tie2_en", 64'(br_cmd_en), 1);
      chk("tie2_addr_c1", 64'(br_addr), 6);
      @(negedge clk);
      feed_rd(1, 64'h400, 1);
      @(negedge clk);
      chk("tie2_en2", 64'(br_cmd_en), 1);
      chk("tie2_addr_c0", 64'(br_addr), 4);
      @(negedge clk);
      feed_rd(0, 64'h500, 1);

      // br_busy stall with c1 pending.
      br_busy = 1;
      req(1, 0, 4'd10, 0, 0);
      @(negedge clk);
      clr_in();
      count_cmd(10, cnt);
      chk("stall_noen", 64'(cnt), 0);
      br_busy = 0;
      @(negedge clk);
      chk("stall_rel_en", 64'(br_cmd_en), 1);
      chk("stall_rel_addr", 64'(br_addr), 10);
      @(negedge clk);
      feed_rd(1, 64'h600, 1);

      // cmd_en while busy is dropped.
      req(0, 0, 4'd12, 0, 0);
      @(negedge clk);
      req(0, 0, 4'd7, 0, 0);
      @(negedge clk);
      clr_in();
      chk("ign_en", 64'(br_cmd_en), 1);
      chk("ign_addr", 64'(br_addr), 12);
      @(negedge clk);
      feed_rd(0, 64'h700, 1);
      count_cmd(6, cnt);
      chk("ign_no_second", 64'(cnt), 0);
      chk("ign_idle_busy", 64'(c0_busy), 0);

      // Reset during WRITE after beat 1.
      req(1, 1, 4'd14, 64'hB0, mk2[0]);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         c1_cmd_en = 0;
         c1_wr_data = 64'hB0 + 64'(i);
         c1_data_mask = mk2[i];
      end
      @(negedge clk);
      clr_in();
      @(negedge clk);
      chk("rw_issue", 64'(br_cmd_en), 1);
      @(negedge clk);
      chk("rw_b1", br_wr_data, 64'hB1);
      #1 rst = 1;
      #1;
      chk("rw_rst_en", 64'(br_cmd_en), 0);
      chk("rw_rst_data", br_wr_data, 0);
      chk("rw_rst_mask", 64'(br_data_mask), 0);
      chk("rw_rst_busy", 64'(c1_busy), 0);
      @(negedge clk);
      rst = 0;
      count_cmd(8, cnt);
      chk("rw_no_cmd", 64'(cnt), 0);
      chk("rw_c1_idle", 64'(c1_busy), 0);

      // Fresh read after the abort.
      req(0, 0, 4'd5, 0, 0);
      @(negedge clk);
      clr_in();
      @(negedge clk);
      chk("post_en", 64'(br_cmd_en), 1);
      chk("post_addr", 64'(br_addr), 5);
      @(negedge clk);
      feed_rd(0, 64'h800, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
